// File: rtl/ula_sequenciador.sv
// rtl/ula_sequenciador.sv - command sequencer for the 4-bit ALU, with multiply by repeated addition
module ula_sequenciador (
  input  logic       clk,
  input  logic       rst,
  input  logic       inicio,
  input  logic [2:0] op,
  input  logic [3:0] op_a,
  input  logic [3:0] op_b,
  input  logic       cin_in,
  output logic       ocupado,
  output logic [3:0] ula_a,
  output logic [3:0] ula_b,
  output logic       ula_cin,
  output logic [2:0] ula_seletor,
  input  logic [3:0] ula_resultado,
  input  logic       ula_cout,
  output logic [3:0] resultado,
  output logic       cout,
  output logic       estouro,
  output logic       erro,
  output logic       pronto
);

  typedef enum logic [1:0] {OCIOSO, EXEC, MULT, PRONTO} estado_t;

  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_RES = 3'b111;

  estado_t    estado;
  logic [2:0] op_q;
  logic [3:0] cont;
  logic [3:0] acum;

  always_ff @(posedge clk) begin
    if (rst) begin
      estado      <= OCIOSO;
      op_q        <= 3'b000;
      cont        <= 4'd0;
      acum        <= 4'd0;
      ocupado     <= 1'b0;
      ula_a       <= 4'd0;
      ula_b       <= 4'd0;
      ula_cin     <= 1'b0;
      ula_seletor <= 3'b000;
      resultado   <= 4'd0;
      cout        <= 1'b0;
      estouro     <= 1'b0;
      erro        <= 1'b0;
      pronto      <= 1'b0;
    end else begin
      pronto <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (inicio) begin
            op_q      <= op;
            resultado <= 4'd0;
            cout      <= 1'b0;
            estouro   <= 1'b0;
            erro      <= 1'b0;
            ocupado   <= 1'b1;
            if (op == OP_MUL) begin
              // ALU computes acum + A each MULT cycle; acum starts at 0
              cont        <= op_b;
              acum        <= 4'd0;
              ula_a       <= 4'd0;
              ula_b       <= op_a;
              ula_cin     <= 1'b0;
              ula_seletor <= OP_ADD;
              estado      <= MULT;
            end else begin
              ula_a       <= op_a;
              ula_b       <= op_b;
              ula_cin     <= (op == OP_ADD) ? cin_in : 1'b0;
              ula_seletor <= op;
              estado      <= EXEC;
            end
          end
        end
        EXEC: begin
          resultado   <= (op_q == OP_RES) ? 4'd0 : ula_resultado;
          cout        <= (op_q == OP_ADD) ? ula_cout : 1'b0;
          erro        <= (op_q == OP_RES);
          ula_a       <= 4'd0;
          ula_b       <= 4'd0;
          ula_cin     <= 1'b0;
          ula_seletor <= 3'b000;
          estado      <= PRONTO;
        end
        MULT: begin
          if (cont != 4'd0) begin
            acum    <= ula_resultado;
            ula_a   <= ula_resultado;
            estouro <= estouro | ula_cout;
            cont    <= cont - 4'd1;
          end else begin
            resultado   <= acum;
            ula_a       <= 4'd0;
            ula_b       <= 4'd0;
            ula_cin     <= 1'b0;
            ula_seletor <= 3'b000;
            estado      <= PRONTO;
          end
        end
        PRONTO: begin
          pronto  <= 1'b1;
          ocupado <= 1'b0;
          estado  <= OCIOSO;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule
